// File: rtl/tff_pkg.sv
// Shared definitions for the T flip-flop counter family.
// Holds the 2-bit operating-mode encoding used by tff_counter.
package tff_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_UP   = 2'b00;
  localparam mode_t MODE_DN   = 2'b01;
  localparam mode_t MODE_TGL  = 2'b10;
  localparam mode_t MODE_HOLD = 2'b11;

endpackage : tff_pkg

// File: rtl/tff_cell.sv
// Single-bit T flip-flop cell with a synchronous set-value override.
// Ports:
//   clk      - rising-edge clock
//   reset_n  - asynchronous active-low reset, forces q to 0
//   t        - toggle request for this edge
//   sv_en    - synchronous set-value enable (takes priority over t)
//   sv       - value loaded when sv_en is high
//   q        - registered cell state
module tff_cell (
  input  logic clk,
  input  logic reset_n,
  input  logic t,
  input  logic sv_en,
  input  logic sv,
  output logic q
);

  logic state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= 1'b0;
    end else if (sv_en) begin
      state_q <= sv;
    end else if (t) begin
      state_q <= ~state_q;
    end
  end

  assign q = state_q;

endmodule : tff_cell

// File: rtl/tff_counter.sv
// Parametrised up/down/toggle counter built from a bank of T cells.
// Ports:
//   clk       - rising-edge clock
//   reset_n   - asynchronous active-low reset
//   en        - advance enable for up/down/toggle modes
//   mode      - 00 up, 01 down, 10 toggle, 11 hold
//   t_mask    - per-bit toggle request, used only in toggle mode
//   clear     - synchronous clear to 0 (highest priority)
//   load      - synchronous parallel load of load_val
//   load_val  - value for load; out-of-range values clamp to MODULUS-1
//   q         - current counter state
//   tc        - terminal count, combinational from q and mode
//   wrap      - one-cycle pulse after a modulus wrap
//   load_err  - one-cycle pulse after an out-of-range load
module tff_counter
  import tff_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] t_mask,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // One extra bit so MODULUS = 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_W   = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] MOD_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] t_up;
  logic [WIDTH-1:0] t_dn;
  logic [WIDTH-1:0] t_d;
  logic [WIDTH-1:0] sv_d;
  logic             sv_en_d;
  logic             wrap_d;
  logic             load_err_d;
  logic             wrap_q;
  logic             load_err_q;
  logic             at_max;
  logic             at_zero;
  logic             load_ok;

  // '>=' rather than '==' so states above the modulus left by toggle
  // mode still wrap back to 0 in up mode.
  assign at_max  = (q_q >= MOD_MAX);
  assign at_zero = (q_q == '0);
  assign load_ok = ({1'b0, load_val} < MOD_W);

  // Carry/borrow chains: bit i toggles when all lower bits are 1 (up)
  // or all lower bits are 0 (down).
  always_comb begin
    logic acc_up;
    logic acc_dn;
    t_up = '0;
    t_dn = '0;
    for (int i = 0; i < WIDTH; i++) begin
      acc_up = 1'b1;
      acc_dn = 1'b1;
      for (int j = 0; j < i; j++) begin
        acc_up = acc_up & q_q[j];
        acc_dn = acc_dn & ~q_q[j];
      end
      t_up[i] = acc_up;
      t_dn[i] = acc_dn;
    end
  end

  // Per-edge control: clear > load > (en and mode). Clear, load and the
  // wrap reload all use the cells' direct set-value path instead of toggles.
  always_comb begin
    t_d        = '0;
    sv_en_d    = 1'b0;
    sv_d       = '0;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (clear) begin
      sv_en_d = 1'b1;
      sv_d    = '0;
    end else if (load) begin
      sv_en_d    = 1'b1;
      sv_d       = load_ok ? load_val : MOD_MAX;
      load_err_d = ~load_ok;
    end else if (en) begin
      case (mode)
        MODE_UP: begin
          if (at_max) begin
            sv_en_d = 1'b1;
            sv_d    = '0;
            wrap_d  = 1'b1;
          end else begin
            t_d = t_up;
          end
        end
        MODE_DN: begin
          // Out-of-range states (q >= MODULUS) are nonzero, so the plain
          // borrow chain already steps them down without a wrap.
          if (at_zero) begin
            sv_en_d = 1'b1;
            sv_d    = MOD_MAX;
            wrap_d  = 1'b1;
          end else begin
            t_d = t_dn;
          end
        end
        MODE_TGL: begin
          t_d = t_mask;
        end
        default: begin
          t_d = '0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    tff_cell u_cell (
      .clk     (clk),
      .reset_n (reset_n),
      .t       (t_d[g]),
      .sv_en   (sv_en_d),
      .sv      (sv_d[g]),
      .q       (q_q[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  // Terminal count is deliberately not gated by en.
  always_comb begin
    tc = 1'b0;
    case (mode)
      MODE_UP: tc = at_max;
      MODE_DN: tc = at_zero;
      default: tc = 1'b0;
    endcase
  end

  assign q        = q_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule : tff_counter

// File: tb/tb_tff_counter.sv
module tb_tff_counter;
  import tff_pkg::*;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         en = 1'b0;
  mode_t        mode = MODE_UP;
  logic [W-1:0] t_mask = '0;
  logic         clear = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] q;
  logic         tc;
  logic         wrap;
  logic         load_err;
  logic         async_chk = 1'b0;

  typedef struct {
    logic [W-1:0] q;
    logic         tc;
    logic         wrap;
    logic         err;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  tff_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .mode     (mode),
    .t_mask   (t_mask),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tc       (tc),
    .wrap     (wrap),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are presented for sampling on every falling edge,
  // or immediately when an asynchronous event is flagged.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or posedge async_chk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (q !== e.q || tc !== e.tc || wrap !== e.wrap || load_err !== e.err) begin
          miscompares++;
          $display("FAIL %s: got q=%0d tc=%0b wrap=%0b load_err=%0b, expected q=%0d tc=%0b wrap=%0b load_err=%0b",
                   e.name, q, tc, wrap, load_err, e.q, e.tc, e.wrap, e.err);
        end
      end
    end
  end

  task automatic push(input logic [W-1:0] eq, input logic etc, input logic ew,
                      input logic ee, input string nm);
    exp_t e;
    e.q = eq; e.tc = etc; e.wrap = ew; e.err = ee; e.name = nm;
    sb.push_back(e);
  endtask

  // One clock: apply inputs, record expected post-edge outputs, then move
  // past the checking edge before the next vector changes any input.
  task automatic step(input logic c, input logic l, input logic [W-1:0] lv,
                      input logic e, input mode_t m, input logic [W-1:0] tm,
                      input logic [W-1:0] eq, input logic etc, input logic ew,
                      input logic ee, input string nm);
    clear = c; load = l; load_val = lv; en = e; mode = m; t_mask = tm;
    @(posedge clk);
    #1;
    push(eq, etc, ew, ee, nm);
    @(negedge clk);
    #1;
  endtask

  task automatic async_check(input logic [W-1:0] eq, input logic etc, input string nm);
    push(eq, etc, 1'b0, 1'b0, nm);
    async_chk = 1'b1;
    #1;
    async_chk = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held from time 0.
    #2;
    async_check(4'd0, 1'b0, "por");
    @(negedge clk); #1;
    @(negedge clk); #1;
    reset_n = 1'b1;

    // Count to 5, then assert reset between edges.
    step(0,0,0, 1,MODE_UP,0, 4'd1,0,0,0, "up1");
    step(0,0,0, 1,MODE_UP,0, 4'd2,0,0,0, "up2");
    step(0,0,0, 1,MODE_UP,0, 4'd3,0,0,0, "up3");
    step(0,0,0, 1,MODE_UP,0, 4'd4,0,0,0, "up4");
    step(0,0,0, 1,MODE_UP,0, 4'd5,0,0,0, "up5");
    en = 1'b0;
    reset_n = 1'b0;
    #1;
    async_check(4'd0, 1'b0, "async_rst");
    @(negedge clk); #1;
    reset_n = 1'b1;

    // Full up count with wrap at MODULUS = 10.
    step(0,0,0, 1,MODE_UP,0, 4'd1,0,0,0, "cnt1");
    step(0,0,0, 1,MODE_UP,0, 4'd2,0,0,0, "cnt2");
    step(0,0,0, 1,MODE_UP,0, 4'd3,0,0,0, "cnt3");
    step(0,0,0, 1,MODE_UP,0, 4'd4,0,0,0, "cnt4");
    step(0,0,0, 1,MODE_UP,0, 4'd5,0,0,0, "cnt5");
    step(0,0,0, 1,MODE_UP,0, 4'd6,0,0,0, "cnt6");
    step(0,0,0, 1,MODE_UP,0, 4'd7,0,0,0, "cnt7");
    step(0,0,0, 1,MODE_UP,0, 4'd8,0,0,0, "cnt8");
    step(0,0,0, 1,MODE_UP,0, 4'd9,1,0,0, "cnt9_tc");
    step(0,0,0, 1,MODE_UP,0, 4'd0,0,1,0, "up_wrap");
    step(0,0,0, 1,MODE_UP,0, 4'd1,0,0,0, "up_wrap_end");

    // Down wrap from 1.
    step(0,1,4'd1, 1,MODE_DN,0, 4'd1,0,0,0, "ld1_dn");
    step(0,0,0,    1,MODE_DN,0, 4'd0,1,0,0, "dn_zero_tc");
    step(0,0,0,    1,MODE_DN,0, 4'd9,0,1,0, "dn_wrap");
    step(0,0,0,    1,MODE_DN,0, 4'd8,0,0,0, "dn_wrap_end");

    // Out-of-range and in-range loads.
    step(0,1,4'd12, 1,MODE_HOLD,0, 4'd9,0,0,1, "ld12_err");
    step(0,0,0,     1,MODE_HOLD,0, 4'd9,0,0,0, "hold_err_end");
    step(0,1,4'd7,  1,MODE_HOLD,0, 4'd7,0,0,0, "ld7_ok");

    // Toggle 0011 ^ 1010 = 1001, then up wrap from 9.
    step(0,1,4'd3, 1,MODE_TGL,0,     4'd3,0,0,0, "ld3");
    step(0,0,0,    1,MODE_TGL,4'hA,  4'd9,0,0,0, "tgl_9");
    step(0,0,0,    1,MODE_UP,0,      4'd0,0,1,0, "tgl_up_wrap");

    // Toggle 0110 ^ 1010 = 1100 (12, above modulus), then down, then up.
    step(0,1,4'd6, 1,MODE_TGL,0,    4'd6,0,0,0,  "ld6");
    step(0,0,0,    1,MODE_TGL,4'hA, 4'd12,0,0,0, "tgl_12");
    step(0,0,0,    1,MODE_DN,0,     4'd11,0,0,0, "dn_from_12");
    step(0,0,0,    1,MODE_UP,0,     4'd0,0,1,0,  "up_from_11");

    // Priority at q = 9 in up mode.
    step(0,1,4'd9, 1,MODE_UP,0, 4'd9,1,0,0, "ld9");
    step(1,1,4'd3, 1,MODE_UP,0, 4'd0,0,0,0, "clr_beats_all");
    step(0,1,4'd9, 1,MODE_UP,0, 4'd9,1,0,0, "ld9_again");
    step(0,1,4'd3, 1,MODE_UP,0, 4'd3,0,0,0, "ld_beats_wrap");

    // tc not gated by en; en low holds.
    step(0,1,4'd9, 0,MODE_UP,0, 4'd9,1,0,0, "ld9_en0");
    step(0,0,0,    0,MODE_UP,0, 4'd9,1,0,0, "en0_hold_tc");
    step(0,1,4'd15,0,MODE_UP,0, 4'd9,1,0,1, "ld15_err");
    step(1,0,0,    0,MODE_UP,0, 4'd0,0,0,0, "clr_err_end");

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries unchecked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_tff_counter
